// File: rtl/ext_arbiter.sv
// ext_arbiter: round-robin share of one 16->32 extension unit.
// Optional grant counters under `define EXT_ARB_STATS_EN.
module ext_arbiter #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [IN_W-1:0]  req0_data,
   input  logic [1:0]       req0_mode,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [IN_W-1:0]  req1_data,
   input  logic [1:0]       req1_mode,
`ifdef EXT_ARB_STATS_EN
   input  logic             stats_clr,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_id
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state;
   logic             last_grant;
   logic             grant0;
   logic             grant1;
   logic             slot_free;
   logic             take0;
   logic             take1;
   logic [IN_W-1:0]  sel_data;
   logic [1:0]       sel_mode;
   logic [OUT_W-1:0] ext_data;

   assign out_valid = (state == FULL);
   assign slot_free = !out_valid || out_ready;

   // Round-robin pick: last_grant=1 means req 0 has priority next.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      priority case (1'b1)
         req0_valid && req1_valid: begin
            grant0 = last_grant;
            grant1 = !last_grant;
         end
         req0_valid: grant0 = 1'b1;
         req1_valid: grant1 = 1'b1;
         default: ;
      endcase
   end

   assign req0_ready = rst_n && grant0 && slot_free;
   assign req1_ready = rst_n && grant1 && slot_free;
   assign take0      = req0_valid && req0_ready;
   assign take1      = req1_valid && req1_ready;

   assign sel_data = take1 ? req1_data : req0_data;
   assign sel_mode = take1 ? req1_mode : req0_mode;

   // Extension of the granted operand by its mode.
   always_comb begin
      ext_data = '0;
      case (sel_mode)
         2'b00: ext_data = {{16{sel_data[15]}}, sel_data};
         2'b01: ext_data = {16'h0, sel_data};
         2'b10: ext_data = {{24{sel_data[7]}}, sel_data[7:0]};
         2'b11: ext_data = {sel_data, 16'h0};
         default: ext_data = '0;
      endcase
   end

   // Result slot FSM with registered data/id and arbitration memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         out_data   <= '0;
         out_id     <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         if (take0 || take1) begin
            out_data   <= ext_data;
            out_id     <= take1;
            last_grant <= take1;
         end
         case (state)
            EMPTY: if (take0 || take1) state <= FULL;
            FULL:  if (out_ready && !(take0 || take1)) state <= EMPTY;
            default: state <= EMPTY;
         endcase
      end
   end

`ifdef EXT_ARB_STATS_EN
   // Saturating per-requester grant counters; clear has priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (stats_clr) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (take0 && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 1'b1;
         if (take1 && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + 1'b1;
      end
   end
`else
   logic [CNT_W-1:0] unused_cnt;
   assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_ext_arbiter.sv
// tb_ext_arbiter: vector table, corner sequences and random
// stimulus against a rule-level model of ext_arbiter.
module tb_ext_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [15:0] req0_data, req1_data;
   logic [1:0]  req0_mode, req1_mode;
   logic        out_valid, out_ready, out_id;
   logic [31:0] out_data;
`ifdef EXT_ARB_STATS_EN
   logic        stats_clr;
   logic [7:0]  grant_cnt0, grant_cnt1;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ext_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_data  (req0_data),
      .req0_mode  (req0_mode),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_data  (req1_data),
      .req1_mode  (req1_mode),
`ifdef EXT_ARB_STATS_EN
      .stats_clr  (stats_clr),
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_id     (out_id)
   );

   typedef struct {
      logic        rq;
      logic [15:0] d;
      logic [1:0]  m;
      logic [31:0] e;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] a,
                        input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, a, e);
      end
   endtask

   function automatic logic [31:0] ref_ext(input logic [15:0] d,
                                           input logic [1:0] m);
      int          s;
      byte         b;
      logic [31:0] r;
      case (m)
         2'd0: begin s = int'($signed(d)); r = s; end
         2'd1: r = 32'(d);
         2'd2: begin b = d[7:0]; s = b; r = s; end
         default: begin r = 32'(d); r = r * 32'd65536; end
      endcase
      return r;
   endfunction

   task automatic idle_inputs();
      req0_valid = 0; req1_valid = 0;
      req0_data = 0; req1_data = 0;
      req0_mode = 0; req1_mode = 0;
      out_ready = 0;
`ifdef EXT_ARB_STATS_EN
      stats_clr = 0;
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   logic        mfull, mid, mlast, slot, p0, p1, tk0, tk1;
   logic [31:0] mdata;
   int          mc0, mc1;
   vec_t        tbl[6];

   initial begin
      tbl[0] = '{1'b0, 16'hF234, 2'b00, 32'hFFFFF234};
      tbl[1] = '{1'b1, 16'hF234, 2'b01, 32'h0000F234};
      tbl[2] = '{1'b1, 16'h1280, 2'b10, 32'hFFFFFF80};
      tbl[3] = '{1'b1, 16'h1234, 2'b11, 32'h12340000};
      tbl[4] = '{1'b0, 16'h7FFF, 2'b00, 32'h00007FFF};
      tbl[5] = '{1'b0, 16'h127F, 2'b10, 32'h0000007F};

      idle_inputs();
      rst_n = 0;
      req0_valid = 1; req1_valid = 1;
      #2;
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_id", out_id, 0);
      check("rst_rdy0", req0_ready, 0);
      check("rst_rdy1", req1_ready, 0);
      do_reset();

      // vector table: one requester at a time, consumer always ready
      for (int i = 0; i < 6; i++) begin
         req0_valid = !tbl[i].rq;
         req1_valid = tbl[i].rq;
         req0_data = tbl[i].d; req1_data = tbl[i].d;
         req0_mode = tbl[i].m; req1_mode = tbl[i].m;
         out_ready = 1;
         #1;
         check("vec_rdy", tbl[i].rq ? req1_ready : req0_ready, 1);
         @(negedge clk);
         check("vec_valid", out_valid, 1);
         check("vec_data", out_data, tbl[i].e);
         check("vec_id", out_id, tbl[i].rq);
      end

      // contention: alternating grants starting at req 0
      do_reset();
      req0_valid = 1; req0_data = 16'h0011; req0_mode = 2'b01;
      req1_valid = 1; req1_data = 16'h0022; req1_mode = 2'b01;
      out_ready = 1;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("cont_rdy0", req0_ready, (i % 2) == 0);
         check("cont_rdy1", req1_ready, (i % 2) == 1);
         @(negedge clk);
         check("cont_valid", out_valid, 1);
         check("cont_id", out_id, i % 2);
         check("cont_data", out_data, (i % 2) ? 32'h22 : 32'h11);
      end

      // back-pressure hold for three cycles
      do_reset();
      req0_valid = 1; req0_data = 16'h8001; req0_mode = 2'b00;
      out_ready = 0;
      #1;
      check("bp_first_rdy", req0_ready, 1);
      @(negedge clk);
      req0_data = 16'h0055; req0_mode = 2'b01;
      req1_valid = 1; req1_data = 16'h00AA; req1_mode = 2'b10;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_rdy0", req0_ready, 0);
         check("bp_rdy1", req1_ready, 0);
         check("bp_valid", out_valid, 1);
         check("bp_data", out_data, 32'hFFFF8001);
         check("bp_id", out_id, 0);
         @(negedge clk);
      end
      out_ready = 1;
      #1;
      check("bp_rel_rdy1", req1_ready, 1);
      check("bp_rel_rdy0", req0_ready, 0);
      @(negedge clk);
      check("bp_next_id", out_id, 1);
      check("bp_next_data", out_data, 32'hFFFFFFAA);

      // asynchronous reset while holding a result
      out_ready = 0;
      #1;
      rst_n = 0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_rdy0", req0_ready, 0);
      check("mid_rst_rdy1", req1_ready, 0);
      @(negedge clk);
      rst_n = 1;
      out_ready = 1;
      #1;
      check("post_rst_rdy0", req0_ready, 1);
      check("post_rst_rdy1", req1_ready, 0);
      @(negedge clk);
      check("post_rst_id", out_id, 0);
      check("post_rst_valid", out_valid, 1);

`ifdef EXT_ARB_STATS_EN
      do_reset();
      req0_valid = 1; out_ready = 1;
      for (int i = 0; i < 300; i++) @(negedge clk);
      check("stat_sat0", grant_cnt0, 255);
      check("stat_cnt1", grant_cnt1, 0);
      req0_valid = 0; req1_valid = 1; stats_clr = 1;
      #1;
      check("stat_clr_rdy1", req1_ready, 1);
      @(negedge clk);
      stats_clr = 0; req1_valid = 0;
      check("stat_clr0", grant_cnt0, 0);
      check("stat_clr1", grant_cnt1, 0);
`endif

      // randomized traffic against the rule-level model
      do_reset();
      mfull = 0; mid = 0; mdata = 0; mlast = 1;
      tk0 = 0; tk1 = 0; mc0 = 0; mc1 = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         check("rnd_valid", out_valid, mfull);
         if (mfull) begin
            check("rnd_data", out_data, mdata);
            check("rnd_id", out_id, mid);
         end
         if (!req0_valid || tk0) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_data = 16'($urandom);
            req0_mode = 2'($urandom);
         end
         if (!req1_valid || tk1) begin
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_data = 16'($urandom);
            req1_mode = 2'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         slot = !mfull || out_ready;
         p1 = req1_valid && (!req0_valid || mlast == 0);
         p0 = req0_valid && !p1;
         tk0 = slot && p0;
         tk1 = slot && p1;
         check("rnd_rdy0", req0_ready, tk0);
         check("rnd_rdy1", req1_ready, tk1);
         if (tk0 || tk1) begin
            mfull = 1;
            mid = tk1;
            mlast = tk1;
            mdata = tk1 ? ref_ext(req1_data, req1_mode)
                        : ref_ext(req0_data, req0_mode);
            if (tk0) mc0 = (mc0 < 255) ? mc0 + 1 : 255;
            if (tk1) mc1 = (mc1 < 255) ? mc1 + 1 : 255;
         end else if (out_ready) begin
            mfull = 0;
         end
      end
`ifdef EXT_ARB_STATS_EN
      @(negedge clk);
      check("rnd_cnt0", grant_cnt0, mc0);
      check("rnd_cnt1", grant_cnt1, mc1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
